mips_dmem_responder: RTL and testbench
======================================

# mips_dmem_responder

Memory-side responder for the MIPS core's data-memory port, replacing the zero-wait combinational data RAM with a handshaked, multi-cycle slave. The core (or a future multi-cycle/pipelined datapath) issues one load or store at a time over a valid/ready request channel. This block performs the access after a configurable number of wait states and returns read data or an error over a valid/ready response channel. It holds one outstanding transaction and performs byte-enabled writes.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits (from mips_param).
- ADDR_WIDTH, 8, log2 of memory depth in words (256 words = 1 KiB).
- LATENCY, 2, wait states between request acceptance and response (0..15).

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  responder can accept a request.
- REQ_ADDR  in  DATA_WIDTH  byte address.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_BE  in  DATA_WIDTH/8  byte enables for stores; ignored for loads.
- REQ_WDATA  in  DATA_WIDTH  store data.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  requester accepts response.
- RSP_RDATA  out  DATA_WIDTH  load data; 0 for stores and errors.
- RSP_ERR  out  1  access was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: REQ_READY=1. On REQ_VALID & REQ_READY, latch ADDR/WE/BE/WDATA and compute err = (ADDR[1:0]!=0) | (ADDR[DATA_WIDTH-1:ADDR_WIDTH+2]!=0). If LATENCY=0, perform the access and go to RESP. Otherwise load counter with LATENCY-1 and go to WAIT.
- WAIT: REQ_READY=0. Decrement the counter. When it is 0, perform the access and go to RESP.
- Access, at the edge entering RESP, using word index ADDR[ADDR_WIDTH+1:2]:
  - Load without error: capture mem[index] into the RSP_RDATA register.
  - Store without error: write each byte i where BE[i]=1; RSP_RDATA=0.
  - Error: no memory write; RSP_RDATA=0; RSP_ERR=1.
- RESP: RSP_VALID=1, with RSP_RDATA and RSP_ERR stable. On RSP_READY, go to IDLE. Otherwise hold all response outputs unchanged.
- REQ_* inputs are ignored outside IDLE. Requester-side changes after acceptance have no effect.
- A store with BE=0 is legal: no bytes change and the response has ERR=0.
- Memory array is not reset. Its contents are undefined until written.

## Timing
- Reset values: state IDLE, REQ_READY=1, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, counter 0.
- RST mid-transaction returns to IDLE on the next edge. A store not yet committed (still in WAIT) is dropped. A committed store persists.
- Request accepted in cycle t gives RSP_VALID=1 from cycle t+1+LATENCY.
- Response consumed in cycle u (RSP_VALID & RSP_READY) gives REQ_READY=1 in cycle u+1. Peak throughput is one transaction per LATENCY+2 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from REQ_* or RSP_READY to any output.
- Read-after-write: a load accepted after a store's response sees the stored data.
- Counter is 4 bits. LATENCY>15 is illegal and must fail an elaboration-time check.

## Structure
- In shared package mips_pkg, next to control_sig_t:
  - dmem_state_t enum {IDLE, WAIT, RESP}.
  - BE_WIDTH = DATA_WIDTH/8.
- DATA_WIDTH continues to come from mips_param.svh.
- Sub-module ram_be holds the storage array:
  - Parameters: ADDR_WIDTH, DATA_WIDTH.
  - Ports: CLK, A, WD, BE, WE, RD; synchronous byte-enabled write.
- The FSM, counter, error decode and response registers live in mips_dmem_responder.

## Test plan
- Reset, then store 0xDEADBEEF to 0x10 with BE=0xF, then load 0x10. Load response has RDATA=0xDEADBEEF, ERR=0. With LATENCY=2, RSP_VALID rises exactly 3 cycles after each accept.
- Store 0x000000AA to 0x10 with BE=0x1, then load 0x10. RDATA=0xDEADBEAA.
- Load from 0x12 (misaligned), then from 0x400 (out of range, ADDR_WIDTH=8). Both give ERR=1 and RDATA=0. A following load from 0x10 still returns 0xDEADBEAA.
- Hold RSP_READY=0 for 5 cycles during RESP. RSP_VALID, RDATA and ERR stay stable and REQ_READY stays 0. Release: REQ_READY=1 on the next cycle.
- LATENCY=0 build with back-to-back requests held valid. Responses appear 1 cycle after each accept, with one transaction every 2 cycles.
- Assert RST during WAIT of a store of 0x12345678 to 0x20. Outputs return to reset values next cycle. A subsequent load from 0x20 does not return 0x12345678 (prior value preserved).

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core types: control word, data-memory responder state and bus widths.
package mips_pkg;

    // Mirrors mips_param.svh so package-level widths agree with the core.
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic       jump;
        logic [2:0] alu_control;
    } control_sig_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

endpackage

// File: rtl/ram_be.sv
// Word-addressed storage with synchronous byte-enabled write and asynchronous read.
module ram_be #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    CLK,
    input  logic [ADDR_WIDTH-1:0]   A,
    input  logic [DATA_WIDTH-1:0]   WD,
    input  logic [DATA_WIDTH/8-1:0] BE,
    input  logic                    WE,
    output logic [DATA_WIDTH-1:0]   RD
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge CLK) begin
        if (WE) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (BE[i]) begin
                    mem[A][8*i +: 8] <= WD[8*i +: 8];
                end
            end
        end
    end

    assign RD = mem[A];

endmodule

// File: rtl/mips_dmem_responder.sv
// Handshaked data-memory slave: one outstanding load/store, fixed wait states,
// registered response carrying read data or an alignment/range error.
module mips_dmem_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    REQ_VALID,
    output logic                    REQ_READY,
    input  logic [DATA_WIDTH-1:0]   REQ_ADDR,
    input  logic                    REQ_WE,
    input  logic [DATA_WIDTH/8-1:0] REQ_BE,
    input  logic [DATA_WIDTH-1:0]   REQ_WDATA,
    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic [DATA_WIDTH-1:0]   RSP_RDATA,
    output logic                    RSP_ERR
);

    import mips_pkg::*;

    localparam int unsigned BEW      = DATA_WIDTH / 8;
    localparam logic [3:0]  CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    if (LATENCY > 15) begin : g_bad_latency
        $error("mips_dmem_responder: LATENCY must be in 0..15");
    end

    dmem_state_t state, state_next;

    logic [3:0]            cnt;
    logic [DATA_WIDTH-1:0] addr_lat, wdata_lat;
    logic                  we_lat;
    logic [BEW-1:0]        be_lat;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rsp_err;

    logic                  accept, access, mem_we;
    logic [DATA_WIDTH-1:0] acc_addr, acc_wdata, mem_rd;
    logic                  acc_we, acc_err;
    logic [BEW-1:0]        acc_be;

    function automatic logic addr_err(input logic [DATA_WIDTH-1:0] a);
        return (a[1:0] != 2'b00) || (a[DATA_WIDTH-1:ADDR_WIDTH+2] != '0);
    endfunction

    assign accept = (state == IDLE) && REQ_VALID;

    // Zero-latency accesses use the live request; otherwise the latched copy.
    always_comb begin
        acc_addr  = addr_lat;
        acc_wdata = wdata_lat;
        acc_we    = we_lat;
        acc_be    = be_lat;
        if (state == IDLE) begin
            acc_addr  = REQ_ADDR;
            acc_wdata = REQ_WDATA;
            acc_we    = REQ_WE;
            acc_be    = REQ_BE;
        end
    end

    assign acc_err = addr_err(acc_addr);
    // Reset wins over a commit landing on the same edge, so an uncommitted store is dropped.
    assign access  = !RST && ((accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == 4'd0)));
    assign mem_we  = access && acc_we && !acc_err;

    ram_be #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .CLK(CLK),
        .A  (acc_addr[ADDR_WIDTH+1:2]),
        .WD (acc_wdata),
        .BE (acc_be),
        .WE (mem_we),
        .RD (mem_rd)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (REQ_VALID) state_next = (LATENCY == 0) ? RESP : WAIT;
            WAIT: if (cnt == 4'd0) state_next = RESP;
            RESP: if (RSP_READY) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        REQ_READY = (state == IDLE);
        RSP_VALID = (state == RESP);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt       <= 4'd0;
            addr_lat  <= '0;
            wdata_lat <= '0;
            we_lat    <= 1'b0;
            be_lat    <= '0;
            rdata     <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                addr_lat  <= REQ_ADDR;
                wdata_lat <= REQ_WDATA;
                we_lat    <= REQ_WE;
                be_lat    <= REQ_BE;
                cnt       <= CNT_LOAD;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                rsp_err <= acc_err;
                rdata   <= (acc_err || acc_we) ? '0 : mem_rd;
            end
        end
    end

    assign RSP_RDATA = rdata;
    assign RSP_ERR   = rsp_err;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: a LATENCY=2 and a LATENCY=0 instance, each checked
// every cycle against a transaction-level model, plus directed literal expectations.
module tb_mips_dmem_responder;

    localparam int N = 2;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [N];
    logic        req_valid [N];
    logic [31:0] req_addr  [N];
    logic        req_we    [N];
    logic [3:0]  req_be    [N];
    logic [31:0] req_wdata [N];
    logic        rsp_ready [N];
    wire         req_ready [N];
    wire         rsp_valid [N];
    wire  [31:0] rsp_rdata [N];
    wire         rsp_err   [N];

    mips_dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LATENCY(2)) u_dut_l2 (
        .CLK(clk), .RST(rst[0]), .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]),
        .REQ_ADDR(req_addr[0]), .REQ_WE(req_we[0]), .REQ_BE(req_be[0]),
        .REQ_WDATA(req_wdata[0]), .RSP_VALID(rsp_valid[0]), .RSP_READY(rsp_ready[0]),
        .RSP_RDATA(rsp_rdata[0]), .RSP_ERR(rsp_err[0])
    );

    mips_dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LATENCY(0)) u_dut_l0 (
        .CLK(clk), .RST(rst[1]), .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]),
        .REQ_ADDR(req_addr[1]), .REQ_WE(req_we[1]), .REQ_BE(req_be[1]),
        .REQ_WDATA(req_wdata[1]), .RSP_VALID(rsp_valid[1]), .RSP_READY(rsp_ready[1]),
        .RSP_RDATA(rsp_rdata[1]), .RSP_ERR(rsp_err[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp, input logic [31:0] mask);
        checks++;
        if (((act ^ exp) & mask) !== 32'd0) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h (mask %h)",
                     name, k, cyc, act, exp, mask);
        end
    endtask

    // Transaction-level model: busy from accept until the response is consumed,
    // access resolved LATENCY cycles after accept against a byte-addressed memory.
    bit          m_busy   [N];
    bit          m_resp   [N];
    bit          m_zero   [N];
    int          m_commit [N];
    logic [31:0] m_addr   [N];
    logic [31:0] m_wdata  [N];
    bit          m_we     [N];
    logic [3:0]  m_be     [N];
    logic [31:0] m_rdata  [N];
    logic [31:0] m_mask   [N];
    bit          m_err    [N];
    logic [7:0]  m_mem    [N][1024];
    bit          m_known  [N][1024];

    task automatic model_commit(input int k);
        int b;
        b = int'(m_addr[k][9:2]) * 4;
        m_resp[k] = 1'b1;
        m_zero[k] = 1'b0;
        m_mask[k] = 32'hFFFF_FFFF;
        m_rdata[k] = 32'd0;
        m_err[k] = (m_addr[k][1:0] != 2'd0) || (m_addr[k][31:10] != 22'd0);
        if (!m_err[k]) begin
            for (int i = 0; i < 4; i++) begin
                if (m_we[k]) begin
                    if (m_be[k][i]) begin
                        m_mem[k][b+i] = m_wdata[k][8*i +: 8];
                        m_known[k][b+i] = 1'b1;
                    end
                end else begin
                    m_rdata[k][8*i +: 8] = m_mem[k][b+i];
                    if (!m_known[k][b+i]) m_mask[k][8*i +: 8] = 8'h00;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst[k]) begin
                m_busy[k] = 1'b0; m_resp[k] = 1'b0; m_zero[k] = 1'b1;
                m_rdata[k] = 32'd0; m_err[k] = 1'b0; m_mask[k] = 32'hFFFF_FFFF;
            end else if (m_resp[k]) begin
                if (rsp_ready[k]) begin
                    m_resp[k] = 1'b0;
                    m_busy[k] = 1'b0;
                end
            end else if (m_busy[k]) begin
                if (cyc == m_commit[k]) model_commit(k);
            end else if (req_valid[k]) begin
                m_addr[k] = req_addr[k]; m_wdata[k] = req_wdata[k];
                m_we[k] = req_we[k]; m_be[k] = req_be[k];
                m_busy[k] = 1'b1;
                m_commit[k] = cyc + lat_of(k);
                if (lat_of(k) == 0) model_commit(k);
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < N; k++) begin
                check("req_ready", k, {31'd0, req_ready[k]}, {31'd0, !m_busy[k]}, 32'd1);
                check("rsp_valid", k, {31'd0, rsp_valid[k]}, {31'd0, m_resp[k]}, 32'd1);
                if (m_resp[k] || m_zero[k]) begin
                    check("rsp_rdata", k, rsp_rdata[k], m_rdata[k], m_mask[k]);
                    check("rsp_err", k, {31'd0, rsp_err[k]}, {31'd0, m_err[k]}, 32'd1);
                end
            end
        end
    end

    // Entered and left just after a rising edge; returns response data and accept-to-valid delay.
    task automatic do_txn(input int k, input bit we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata, input int hold,
                          output logic [31:0] rd, output logic er, output int lat);
        int acc = -1;
        int v = -1;
        rd = 32'd0; er = 1'b0; lat = -1;
        req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr;
        req_be[k] = be; req_wdata[k] = wdata; rsp_ready[k] = 1'b0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (req_ready[k]) begin
                acc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        check("accept_in_time", k, {31'd0, acc >= 0}, 32'd1, 32'd1);
        @(posedge clk); #1;
        req_valid[k] = 1'b0; req_addr[k] = $urandom; req_wdata[k] = $urandom;
        req_we[k] = 1'($urandom); req_be[k] = 4'($urandom);
        if (acc < 0) return;
        for (int w = 0; w < 40; w++) begin
            @(negedge clk);
            if (rsp_valid[k]) begin
                v = cyc;
                break;
            end
        end
        check("response_in_time", k, {31'd0, v >= 0}, 32'd1, 32'd1);
        if (v < 0) return;
        lat = v - acc;
        rd = rsp_rdata[k];
        er = rsp_err[k];
        for (int h = 0; h < hold; h++) begin
            check("hold_rdata", k, rsp_rdata[k], rd, 32'hFFFF_FFFF);
            check("hold_err", k, {31'd0, rsp_err[k]}, {31'd0, er}, 32'd1);
            check("hold_valid", k, {31'd0, rsp_valid[k]}, 32'd1, 32'd1);
            check("hold_req_ready", k, {31'd0, req_ready[k]}, 32'd0, 32'd1);
            @(negedge clk);
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[k] = 1'b0;
        if (hold > 0) begin
            @(negedge clk);
            check("ready_after_release", k, {31'd0, req_ready[k]}, 32'd1, 32'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic drive(input int k);
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n_acc;
        logic [31:0] a;
        int          r;

        do_txn(k, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, rd, er, lat);
        check("store_latency", k, lat, 1 + lat_of(k), 32'hFFFF_FFFF);
        check("store_rdata_zero", k, rd, 32'd0, 32'hFFFF_FFFF);
        do_txn(k, 1'b0, 32'h10, 4'h0, 32'h0, 0, rd, er, lat);
        check("load_latency", k, lat, 1 + lat_of(k), 32'hFFFF_FFFF);
        check("load_full_word", k, rd, 32'hDEADBEEF, 32'hFFFF_FFFF);
        check("load_full_err", k, {31'd0, er}, 32'd0, 32'd1);

        do_txn(k, 1'b1, 32'h10, 4'h1, 32'h000000AA, 0, rd, er, lat);
        do_txn(k, 1'b0, 32'h10, 4'hF, 32'h0, 0, rd, er, lat);
        check("load_byte_merge", k, rd, 32'hDEADBEAA, 32'hFFFF_FFFF);

        do_txn(k, 1'b0, 32'h12, 4'hF, 32'h0, 0, rd, er, lat);
        check("misaligned_err", k, {31'd0, er}, 32'd1, 32'd1);
        check("misaligned_rdata", k, rd, 32'd0, 32'hFFFF_FFFF);
        do_txn(k, 1'b0, 32'h400, 4'hF, 32'h0, 0, rd, er, lat);
        check("range_err", k, {31'd0, er}, 32'd1, 32'd1);
        check("range_rdata", k, rd, 32'd0, 32'hFFFF_FFFF);
        do_txn(k, 1'b1, 32'h10, 4'h0, 32'h55555555, 0, rd, er, lat);
        check("be_zero_err", k, {31'd0, er}, 32'd0, 32'd1);
        do_txn(k, 1'b0, 32'h10, 4'h0, 32'h0, 5, rd, er, lat);
        check("load_after_errors", k, rd, 32'hDEADBEAA, 32'hFFFF_FFFF);

        if (lat_of(k) > 0) begin
            do_txn(k, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 0, rd, er, lat);
            req_valid[k] = 1'b1; req_we[k] = 1'b1; req_addr[k] = 32'h20;
            req_be[k] = 4'hF; req_wdata[k] = 32'h12345678;
            @(posedge clk); #1;
            req_valid[k] = 1'b0;
            rst[k] = 1'b1;
            @(posedge clk); #1;
            rst[k] = 1'b0;
            @(negedge clk);
            check("rst_req_ready", k, {31'd0, req_ready[k]}, 32'd1, 32'd1);
            check("rst_rsp_valid", k, {31'd0, rsp_valid[k]}, 32'd0, 32'd1);
            check("rst_rdata", k, rsp_rdata[k], 32'd0, 32'hFFFF_FFFF);
            @(posedge clk); #1;
            do_txn(k, 1'b0, 32'h20, 4'hF, 32'h0, 0, rd, er, lat);
            check("dropped_store", k, rd, 32'hCAFEF00D, 32'hFFFF_FFFF);
        end

        // Back-to-back requests held valid with the response always accepted.
        req_valid[k] = 1'b1; req_we[k] = 1'b0; req_addr[k] = 32'h10; rsp_ready[k] = 1'b1;
        n_acc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_ready[k]) n_acc++;
            @(posedge clk); #1;
        end
        check("throughput", k, n_acc, 12 / (lat_of(k) + 2), 32'hFFFF_FFFF);
        req_valid[k] = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        for (int c = 0; c < 600; c++) begin
            r = int'($urandom_range(9, 0));
            if (r < 7) a = 32'($urandom_range(15, 0)) << 2;
            else if (r == 7) a = 32'($urandom_range(63, 0)) | 32'h1;
            else if (r == 8) a = ($urandom & 32'hFFFF_FFFC) | 32'h400;
            else a = 32'($urandom_range(255, 0)) << 2;
            rst[k] = ($urandom_range(59, 0) == 0);
            req_valid[k] = 1'($urandom);
            req_addr[k] = a;
            req_we[k] = 1'($urandom);
            req_be[k] = 4'($urandom);
            req_wdata[k] = $urandom;
            rsp_ready[k] = ($urandom_range(3, 0) != 0);
            @(posedge clk); #1;
        end
        rst[k] = 1'b0; req_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_addr[k] = 32'd0; req_we[k] = 1'b0;
            req_be[k] = 4'd0; req_wdata[k] = 32'd0; rsp_ready[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("reset_req_ready", k, {31'd0, req_ready[k]}, 32'd1, 32'd1);
            check("reset_rsp_valid", k, {31'd0, rsp_valid[k]}, 32'd0, 32'd1);
            check("reset_rdata", k, rsp_rdata[k], 32'd0, 32'hFFFF_FFFF);
            check("reset_err", k, {31'd0, rsp_err[k]}, 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        check_en = 1'b1;
        fork
            drive(0);
            drive(1);
        join
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
